// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg: shared FSM states and AXI constants for the weight loader.
package weight_loader_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [3:0] WSTRB_ALL = 4'hF;
  localparam int WORD_STRIDE = 4;
endpackage

// File: rtl/weight_loader.sv
// weight_loader: AXI4-Lite master streaming weights into consecutive words, with optional read-back checksum.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int N_WEIGHTS = 5,
  parameter int ADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR = 0,
  parameter int VERIFY = 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  start,
  input  logic [31:0]           w_tdata,
  input  logic                  w_tvalid,
  output logic                  w_tready,
  output logic [ADDR_WIDTH-1:0] M_AXI_awaddr,
  output logic [2:0]            M_AXI_awprot,
  output logic                  M_AXI_awvalid,
  input  logic                  M_AXI_awready,
  output logic [31:0]           M_AXI_wdata,
  output logic [3:0]            M_AXI_wstrb,
  output logic                  M_AXI_wvalid,
  input  logic                  M_AXI_wready,
  input  logic [1:0]            M_AXI_bresp,
  input  logic                  M_AXI_bvalid,
  output logic                  M_AXI_bready,
  output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
  output logic [2:0]            M_AXI_arprot,
  output logic                  M_AXI_arvalid,
  input  logic                  M_AXI_arready,
  input  logic [31:0]           M_AXI_rdata,
  input  logic [1:0]            M_AXI_rresp,
  input  logic                  M_AXI_rvalid,
  output logic                  M_AXI_rready,
  output logic                  busy,
  output logic                  done,
  output logic                  resp_err,
  output logic                  sum_err,
  output logic [31:0]           wr_sum,
  output logic [31:0]           rd_sum
);
  localparam int IW = N_WEIGHTS > 1 ? $clog2(N_WEIGHTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_WEIGHTS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(WORD_STRIDE);

  state_t state, next;
  logic [IW-1:0] idx;
  logic [ADDR_WIDTH-1:0] addr;
  logic aw_done, w_done, aw_hs, w_hs, last;

  assign aw_hs = M_AXI_awvalid & M_AXI_awready;
  assign w_hs = M_AXI_wvalid & M_AXI_wready;
  assign last = idx == LAST;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? FETCH : IDLE;
      FETCH:   next = w_tvalid ? WR_ADDR : FETCH;
      WR_ADDR: next = ((aw_done | aw_hs) && (w_done | w_hs)) ? WR_RESP : WR_ADDR;
      WR_RESP: next = !M_AXI_bvalid ? WR_RESP : !last ? FETCH : (VERIFY != 0) ? RD_ADDR : DONE;
      RD_ADDR: next = M_AXI_arready ? RD_DATA : RD_ADDR;
      RD_DATA: next = !M_AXI_rvalid ? RD_DATA : last ? DONE : RD_ADDR;
      DONE:    next = start ? DONE : IDLE;
      default: next = IDLE;
    endcase
  end

  // Every output decodes registered state only, so no input reaches an output combinationally.
  always_comb begin
    w_tready = state == FETCH;
    M_AXI_awvalid = state == WR_ADDR && !aw_done;
    M_AXI_wvalid = state == WR_ADDR && !w_done;
    M_AXI_bready = state == WR_RESP;
    M_AXI_arvalid = state == RD_ADDR;
    M_AXI_rready = state == RD_DATA;
    M_AXI_awaddr = addr;
    M_AXI_araddr = addr;
    M_AXI_awprot = '0;
    M_AXI_arprot = '0;
    M_AXI_wstrb = WSTRB_ALL;
    busy = state != IDLE && state != DONE;
    done = state == DONE;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      idx <= '0;
      addr <= '0;
      M_AXI_wdata <= '0;
      wr_sum <= '0;
      rd_sum <= '0;
      resp_err <= 1'b0;
      sum_err <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx <= '0;
          addr <= BASE;
          wr_sum <= '0;
          rd_sum <= '0;
          resp_err <= 1'b0;
          sum_err <= 1'b0;
        end
        FETCH: if (w_tvalid) begin
          M_AXI_wdata <= w_tdata;
          wr_sum <= wr_sum + w_tdata;
          aw_done <= 1'b0;
          w_done <= 1'b0;
        end
        WR_ADDR: begin
          aw_done <= aw_done | aw_hs;
          w_done <= w_done | w_hs;
        end
        WR_RESP: if (M_AXI_bvalid) begin
          resp_err <= resp_err | (M_AXI_bresp != AXI_RESP_OKAY);
          idx <= last ? '0 : idx + IW'(1);
          addr <= last ? BASE : addr + STRIDE;
        end
        RD_DATA: if (M_AXI_rvalid) begin
          rd_sum <= rd_sum + M_AXI_rdata;
          resp_err <= resp_err | (M_AXI_rresp != AXI_RESP_OKAY);
          if (last) sum_err <= (rd_sum + M_AXI_rdata) != wr_sum;
          else begin
            idx <= idx + IW'(1);
            addr <= addr + STRIDE;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: table-driven jobs against an AXI-Lite memory model, plus handshake and reset sequences.
module tb_weight_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] w_tdata;
  logic w_tvalid, w_tready;
  logic [11:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, wr_sum, rd_sum;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic busy, done, resp_err, sum_err;

  always #5 clk = ~clk;

  weight_loader #(.N_WEIGHTS(5), .ADDR_WIDTH(12), .BASE_ADDR(0), .VERIFY(1)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready),
    .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
    .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
    .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready),
    .busy(busy), .done(done), .resp_err(resp_err), .sum_err(sum_err),
    .wr_sum(wr_sum), .rd_sum(rd_sum)
  );

  typedef struct {
    int aw_dly, w_dly, bad_b, corrupt, stall_idx, stall_len;
    logic [31:0] wbase, exp_wr, exp_rd;
    logic exp_resp, exp_sum;
    int exp_stall;
  } vec_t;

  int tests = 0, fails = 0;
  int aw_dly = 0, w_dly = 0, bad_b = -1, corrupt = 0, stall_idx = -1, stall_len = 0;
  logic [31:0] wbase = 32'd1;
  logic job_clr = 1'b0;

  // Weight producer: weight k is wbase+k, with an optional stall before one index.
  int wi, stall_cnt;
  assign w_tvalid = wi < 5 && !(wi == stall_idx && stall_cnt < stall_len);
  assign w_tdata = wbase + 32'(wi);
  always @(posedge clk)
    if (!rst_n || job_clr) begin
      wi <= 0;
      stall_cnt <= 0;
    end else if (w_tvalid && w_tready) wi <= wi + 1;
    else if (wi == stall_idx && stall_cnt < stall_len) stall_cnt <= stall_cnt + 1;

  // Memory slave: programmable awready/wready delay, error bresp on one write, corrupted read at 0x10.
  int aw_cnt, w_cnt, bcnt, wlog_n;
  logic got_aw, got_w;
  logic [11:0] aw_a, cur_a;
  logic [31:0] w_d, cur_d;
  logic [31:0] mem [0:7];
  logic [11:0] wlog [0:7];
  assign awready = awvalid && aw_cnt >= aw_dly;
  assign wready = wvalid && w_cnt >= w_dly;
  assign arready = arvalid;
  assign cur_a = got_aw ? aw_a : awaddr;
  assign cur_d = got_w ? w_d : wdata;
  always @(posedge clk)
    if (!rst_n || job_clr) begin
      aw_cnt <= 0; w_cnt <= 0; bcnt <= 0; wlog_n <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      for (int i = 0; i < 8; i++) begin mem[i] <= '0; wlog[i] <= '0; end
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (awvalid && awready) begin got_aw <= 1'b1; aw_a <= awaddr; end
      if (wvalid && wready) begin got_w <= 1'b1; w_d <= wdata; end
      if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready)) && !bvalid) begin
        mem[cur_a[4:2]] <= cur_d;
        wlog[wlog_n[2:0]] <= cur_a;
        wlog_n <= wlog_n + 1;
        got_aw <= 1'b0;
        got_w <= 1'b0;
        bvalid <= 1'b1;
        bresp <= (wlog_n == bad_b) ? 2'b10 : 2'b00;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; bcnt <= bcnt + 1; end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata <= (corrupt != 0 && araddr == 12'h10) ? 32'd6 : mem[araddr[4:2]];
      end else if (rvalid && rready) rvalid <= 1'b0;
    end

  // Stall monitor: FETCH cycles without a weight, and any AXI valid/ready seen during them.
  int stall_seen, stall_viol;
  always @(negedge clk)
    if (job_clr) begin
      stall_seen <= 0;
      stall_viol <= 0;
    end else if (w_tready && !w_tvalid) begin
      stall_seen <= stall_seen + 1;
      if (awvalid | wvalid | arvalid | bready | rready) stall_viol <= stall_viol + 1;
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic configure(input vec_t v);
    aw_dly = v.aw_dly; w_dly = v.w_dly; bad_b = v.bad_b; corrupt = v.corrupt;
    stall_idx = v.stall_idx; stall_len = v.stall_len; wbase = v.wbase;
    @(negedge clk) job_clr = 1'b1;
    @(negedge clk) #1 job_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 400 && !done; c++) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic check_row(input vec_t v, input string tag);
    check({tag, "_wr_sum"}, wr_sum, v.exp_wr);
    check({tag, "_rd_sum"}, rd_sum, v.exp_rd);
    check({tag, "_resp_err"}, 32'(resp_err), 32'(v.exp_resp));
    check({tag, "_sum_err"}, 32'(sum_err), 32'(v.exp_sum));
    check({tag, "_stall_cycles"}, 32'(stall_seen), 32'(v.exp_stall));
    check({tag, "_stall_valids"}, 32'(stall_viol), 32'd0);
    check({tag, "_writes"}, 32'(wlog_n), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s_addr%0d", tag, k), 32'(wlog[k]), 32'(4 * k));
      check($sformatf("%s_mem%0d", tag, k), mem[k], v.wbase + 32'(k));
    end
  endtask

  task automatic finish_job(input string tag);
    @(negedge clk);
    check({tag, "_done_held"}, 32'(done), 32'd1);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_clear"}, 32'(done), 32'd0);
  endtask

  vec_t vecs [8];
  logic [4:0] av, wv, bq;
  logic aa_ok;

  initial begin
    vecs[0] = '{0, 0, -1, 0, -1, 0, 32'd1, 32'd15, 32'd15, 1'b0, 1'b0, 0};
    vecs[1] = '{3, 0, -1, 0, -1, 0, 32'd1, 32'd15, 32'd15, 1'b0, 1'b0, 0};
    vecs[2] = '{0, 2, -1, 0, -1, 0, 32'd1, 32'd15, 32'd15, 1'b0, 1'b0, 0};
    vecs[3] = '{0, 0, 2, 0, -1, 0, 32'd1, 32'd15, 32'd15, 1'b1, 1'b0, 0};
    vecs[4] = '{0, 0, -1, 1, -1, 0, 32'd1, 32'd15, 32'd16, 1'b0, 1'b1, 0};
    vecs[5] = '{0, 0, -1, 0, 3, 10, 32'd1, 32'd15, 32'd15, 1'b0, 1'b0, 8};
    vecs[6] = '{1, 1, -1, 0, -1, 0, 32'hFFFF_FFF0, 32'hFFFF_FFBA, 32'hFFFF_FFBA, 1'b0, 1'b0, 0};
    vecs[7] = '{2, 1, 4, 1, -1, 0, 32'd1, 32'd15, 32'd16, 1'b1, 1'b1, 0};

    repeat (2) @(negedge clk);
    check("reset_ctrl", 32'({w_tready, awvalid, wvalid, bready, arvalid, rready, busy, done, resp_err, sum_err}), 32'd0);
    check("reset_data", wr_sum | rd_sum | wdata | 32'(awaddr) | 32'(araddr), 32'd0);
    check("wstrb_prot", 32'({wstrb, awprot, arprot}), 32'h3C0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      configure(vecs[i]);
      start = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      wait_done($sformatf("v%0d", i));
      check_row(vecs[i], $sformatf("v%0d", i));
      finish_job($sformatf("v%0d", i));
    end

    // awready 3 cycles late, wready immediate: observe the first write's channel timing.
    configure(vecs[1]);
    start = 1'b1;
    for (int c = 0; c < 20 && !awvalid; c++) @(negedge clk);
    check("seqA_awvalid_seen", 32'(awvalid), 32'd1);
    aa_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      av[k] = awvalid; wv[k] = wvalid; bq[k] = bready;
      if (k < 4 && awaddr != 12'h0) aa_ok = 1'b0;
      @(negedge clk);
    end
    check("seqA_awvalid_cycles", 32'(av), 32'h0F);
    check("seqA_wvalid_cycles", 32'(wv), 32'h01);
    check("seqA_bready_cycles", 32'(bq), 32'h10);
    check("seqA_awaddr_stable", 32'(aa_ok), 32'd1);
    wait_done("seqA");
    check("seqA_wr_sum", wr_sum, 32'd15);
    finish_job("seqA");

    // Reset while waiting for the response of weight 1, then rerun from scratch.
    configure(vecs[0]);
    start = 1'b1;
    for (int c = 0; c < 40 && !(bready && bcnt == 1); c++) @(negedge clk);
    check("seqR_reached_wr_resp1", 32'(bready && bcnt == 1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("seqR_ctrl_async", 32'({w_tready, awvalid, wvalid, bready, arvalid, rready, busy, done, resp_err, sum_err}), 32'd0);
    check("seqR_data_async", wr_sum | rd_sum | wdata | 32'(awaddr) | 32'(araddr), 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("seqR_ctrl_held", 32'({busy, done, awvalid, wvalid, bready}), 32'd0);
    rst_n = 1'b1;
    configure(vecs[0]);
    start = 1'b1;
    wait_done("seqR");
    check_row(vecs[0], "seqR");
    finish_job("seqR");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/weight_loader.md
# weight_loader

AXI4-Lite master that fetches `N_WEIGHTS` 32-bit weights from a valid/ready input stream and writes them into a perceptron's AXI-Lite weight BRAM at consecutive word addresses. It optionally reads the range back and compares additive checksums. It is the initiator side of the perceptron's `S_AXI_*` port, driven on-chip by the network controller before the perceptron is started.

## Interface
- `N_WEIGHTS`, 5: number of weights per job (≥1).
- `ADDR_WIDTH`, 12: AXI address width.
- `BASE_ADDR`, 0: byte address of weight 0.
- `VERIFY`, 1: 1 enables the read-back phase.
- `s_axi_aclk` in 1: clock.
- `s_axi_aresetn` in 1: asynchronous, active-low reset.
- `start` in 1: begins a job when high in IDLE.
- `w_tdata` in 32: weight stream data.
- `w_tvalid` in 1: weight valid.
- `w_tready` out 1: weight accepted when `w_tvalid & w_tready`.
- `M_AXI_awaddr` out ADDR_WIDTH, `M_AXI_awprot` out 3, `M_AXI_awvalid` out 1, `M_AXI_awready` in 1: write address channel.
- `M_AXI_wdata` out 32, `M_AXI_wstrb` out 4, `M_AXI_wvalid` out 1, `M_AXI_wready` in 1: write data channel.
- `M_AXI_bresp` in 2, `M_AXI_bvalid` in 1, `M_AXI_bready` out 1: write response channel.
- `M_AXI_araddr` out ADDR_WIDTH, `M_AXI_arprot` out 3, `M_AXI_arvalid` out 1, `M_AXI_arready` in 1: read address channel.
- `M_AXI_rdata` in 32, `M_AXI_rresp` in 2, `M_AXI_rvalid` in 1, `M_AXI_rready` out 1: read data channel.
- `busy` out 1: job in progress.
- `done` out 1: job complete; held until `start` is low.
- `resp_err` out 1: sticky; any `bresp` or `rresp` ≠ OKAY (2'b00).
- `sum_err` out 1: read-back checksum ≠ write checksum (VERIFY=1 only).
- `wr_sum` out 32, `rd_sum` out 32: checksums, sum mod 2^32.

## Operation
- States: IDLE → FETCH → WR_ADDR → WR_RESP → (FETCH | RD_ADDR | DONE); RD_ADDR → RD_DATA → (RD_ADDR | DONE); DONE → IDLE when `start` is low.
- IDLE with `start` high: clears `idx`, `wr_sum`, `rd_sum`, `resp_err`, `sum_err`; sets `busy`; goes to FETCH.
- FETCH: `w_tready` = 1; on handshake, latch `w_tdata` into `wdata`, add it to `wr_sum`, go to WR_ADDR. `w_tvalid` low stalls the FSM indefinitely.
- WR_ADDR: `awvalid` and `wvalid` rise together.
  - Each valid drops independently in the cycle after its own handshake.
  - When both channels have completed their handshakes, go to WR_RESP.
- WR_RESP: `bready` = 1; on `bvalid`, OR (`bresp` ≠ 0) into `resp_err`.
  - If `idx` = N_WEIGHTS-1: go to RD_ADDR (VERIFY=1) or DONE (VERIFY=0), resetting `idx` to 0.
  - Otherwise increment `idx` and go to FETCH.
- RD_ADDR: `arvalid` = 1 until `arready`, then go to RD_DATA.
- RD_DATA: `rready` = 1; on `rvalid`, add `rdata` to `rd_sum` and OR in `rresp` ≠ 0.
  - On the last index: go to DONE and set `sum_err` = (`rd_sum`+`rdata` ≠ `wr_sum`).
  - Otherwise increment `idx` and go to RD_ADDR.
- DONE: `done` = 1, `busy` = 0.
- Address: `awaddr` = `araddr` = BASE_ADDR + 4·`idx`, truncated to ADDR_WIDTH (wraps).
- Constants: `awprot` = `arprot` = 0; `wstrb` = 4'hF.
- `start` dropping mid-job is ignored; the job runs to completion.
- Error responses do not abort the job.

## Timing
- Reset (asynchronous, immediate): state IDLE.
  - All valids, readies, `busy`, `done`, error flags: 0.
  - Addresses, `wdata`, sums: 0.
  - In-flight transactions are abandoned.
- All outputs are registered; no combinational path from inputs to outputs.
- `awaddr`/`wdata` are stable while their valids are high; `araddr` is stable while `arvalid` is high.
- Zero-wait slave: 3 cycles per write (FETCH, WR_ADDR, WR_RESP) with `w_tvalid` already high; 2 cycles per read.
- `done` rises the cycle after the final `bvalid` (VERIFY=0) or the final `rvalid` (VERIFY=1).
- `awready` and `wready` may arrive in any order or cycle; both are required before `bready` is asserted.

## Structure
- `weight_loader_pkg` holds:
  - the state enum;
  - `AXI_RESP_OKAY` = 2'b00;
  - `WSTRB_ALL` = 4'hF;
  - the word stride of 4.
- Single module; no sub-module. FSM, index counter and checksum datapath all live in `weight_loader`.

## Test plan
- Weights 1,2,3,4,5, BASE_ADDR 0, perceptron as slave, VERIFY=1 → writes to 0x0,0x4,0x8,0xC,0x10; `wr_sum` = `rd_sum` = 15; `done` = 1; both error flags 0.
- `awready` delayed 3 cycles, `wready` immediate on weight 0 → `wvalid` drops after 1 cycle; `awvalid` held 4 cycles with `awaddr` = 0 stable; `bready` only after both handshakes.
- Slave returns `bresp` = 2'b10 on write 2 → `resp_err` = 1; remaining writes and reads still complete; `done` = 1.
- Memory model returns 6 at 0x10 → `rd_sum` = 16, `wr_sum` = 15, `sum_err` = 1.
- `w_tvalid` low 10 cycles before weight 3 → FSM held in FETCH with no AXI valids asserted; job then completes normally.
- Reset asserted in WR_RESP of weight 1, then released, then `start` → all outputs 0 during reset; new job rewrites from address 0 and finishes with `wr_sum` = 15.
